// File: rtl/fma_write_buffer.sv
// Packs per-lane FMA result words into cache lines and queues completed lines
// in a small FIFO whose registered head feeds the data-cache memory.
module fma_write_buffer #(
  parameter int unsigned FMA_COUNT  = 2,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned LINE_WIDTH = 96,
  parameter int unsigned LINE_DEPTH = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0]   fma_result_in,
  input  logic [FMA_COUNT-1:0]              fma_valid_in,
  input  logic                              flush_in,
  input  logic                              write_buffer_ack_in,
  output logic [LINE_WIDTH-1:0]             write_buffer_out,
  output logic                              write_buffer_valid_out,
  output logic                              full_out,
  output logic [$clog2(LINE_DEPTH+1)-1:0]   line_count_out,
  output logic                              idle_out,
  output logic                              overflow_error_out
);

  localparam int unsigned WPL    = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned EXT    = WPL + FMA_COUNT;
  localparam int unsigned TW     = $clog2(EXT + 1);
  localparam int unsigned EXT_SZ = 1 << TW;
  localparam int unsigned FW     = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned PW     = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam int unsigned CW     = $clog2(LINE_DEPTH + 1);

  logic [WPL-1:0][WORD_WIDTH-1:0]        asm_q, asm_n;
  logic [FW-1:0]                         fill_q, fill_n;
  logic                                  pend_q, pend_n;
  logic [LINE_DEPTH-1:0][LINE_WIDTH-1:0] mem_q;
  logic [PW-1:0]                         wr_ptr_q, rd_ptr_q, rd_ptr_n;
  logic [CW-1:0]                         count_q, count_n;
  logic [LINE_WIDTH-1:0]                 out_q, head_n, line;
  logic                                  valid_q, ovf_q;

  logic [EXT_SZ-1:0][WORD_WIDTH-1:0]     ext;
  logic [TW-1:0]                         total;
  logic                                  do_flush, push, pop, full, wr_en, drop;

  // Append valid lanes after the current fill, then decide push / leftover / flush.
  always_comb begin
    ext      = '0;
    asm_n    = '0;
    fill_n   = '0;
    pend_n   = 1'b0;
    push     = 1'b0;
    line     = '0;
    do_flush = flush_in | pend_q;
    for (int s = 0; s < WPL; s++) ext[s] = asm_q[s];
    total = TW'(fill_q);
    for (int i = 0; i < FMA_COUNT; i++) begin
      if (fma_valid_in[i]) begin
        ext[total] = fma_result_in[i*WORD_WIDTH +: WORD_WIDTH];
        total      = total + TW'(1);
      end
    end
    for (int s = 0; s < WPL; s++) line[LINE_WIDTH-(s+1)*WORD_WIDTH +: WORD_WIDTH] = ext[s];

    if (total >= TW'(WPL)) begin
      push   = 1'b1;
      for (int s = 0; s < FMA_COUNT; s++) asm_n[s] = ext[WPL+s];
      fill_n = FW'(total - TW'(WPL));
      pend_n = do_flush && (total != TW'(WPL));
    end else if (do_flush) begin
      // Slots beyond the fill are always zero, so the line is already padded.
      push = (total != '0);
    end else begin
      for (int s = 0; s < WPL; s++) asm_n[s] = ext[s];
      fill_n = FW'(total);
    end
  end

  // FIFO bookkeeping; a full FIFO accepts a push only alongside a pop.
  always_comb begin
    pop      = write_buffer_ack_in & valid_q;
    full     = (count_q == CW'(LINE_DEPTH));
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;
    count_n  = count_q + CW'(wr_en) - CW'(pop);
    rd_ptr_n = rd_ptr_q + PW'(pop);
    head_n   = (wr_en && (wr_ptr_q == rd_ptr_n)) ? line : mem_q[rd_ptr_n];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      asm_q    <= '0;
      fill_q   <= '0;
      pend_q   <= 1'b0;
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      asm_q    <= asm_n;
      fill_q   <= fill_n;
      pend_q   <= pend_n;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= line;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      valid_q  <= (count_n != '0);
      out_q    <= (count_n != '0) ? head_n : '0;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign write_buffer_out       = out_q;
  assign write_buffer_valid_out = valid_q;
  assign full_out               = full;
  assign line_count_out         = count_q;
  assign idle_out               = (count_q == '0) && (fill_q == '0) && !pend_q;
  assign overflow_error_out     = ovf_q;

endmodule

// File: tb/tb_fma_write_buffer.sv
// Directed bench for fma_write_buffer: table of single-cycle vectors plus
// hand sequences for FIFO full/overflow and mid-operation reset.
module tb_fma_write_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] fma_result_in;
  logic [1:0]  fma_valid_in;
  logic        flush_in;
  logic        write_buffer_ack_in;
  logic [95:0] write_buffer_out;
  logic        write_buffer_valid_out;
  logic        full_out;
  logic [2:0]  line_count_out;
  logic        idle_out;
  logic        overflow_error_out;

  int n_pass = 0;
  int n_total = 0;

  fma_write_buffer dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .fma_result_in         (fma_result_in),
    .fma_valid_in          (fma_valid_in),
    .flush_in              (flush_in),
    .write_buffer_ack_in   (write_buffer_ack_in),
    .write_buffer_out      (write_buffer_out),
    .write_buffer_valid_out(write_buffer_valid_out),
    .full_out              (full_out),
    .line_count_out        (line_count_out),
    .idle_out              (idle_out),
    .overflow_error_out    (overflow_error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]  v;
    logic [15:0] r0;
    logic [15:0] r1;
    logic        fl;
    logic        ack;
    logic        ev;
    logic [95:0] eo;
    logic [2:0]  ec;
    logic        ei;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs applied at a falling edge, outputs observed at the next falling edge.
  task automatic cyc(input logic [1:0] v, input logic [15:0] r0, input logic [15:0] r1,
                     input logic fl, input logic ack);
    fma_valid_in        = v;
    fma_result_in       = {r1, r0};
    flush_in            = fl;
    write_buffer_ack_in = ack;
    @(negedge clk_in);
  endtask

  task automatic check_state(input string tag, input logic ev, input logic [95:0] eo,
                             input logic [2:0] ec, input logic ef, input logic ei, input logic eov);
    check({tag, ".valid"}, 96'(write_buffer_valid_out), 96'(ev));
    check({tag, ".line"},  write_buffer_out, eo);
    check({tag, ".count"}, 96'(line_count_out), 96'(ec));
    check({tag, ".full"},  96'(full_out), 96'(ef));
    check({tag, ".idle"},  96'(idle_out), 96'(ei));
    check({tag, ".ovf"},   96'(overflow_error_out), 96'(eov));
  endtask

  function automatic logic [95:0] mkline(input logic [15:0] b);
    return {b, 16'(b + 1), 16'(b + 2), 16'(b + 3), 16'(b + 4), 16'(b + 5)};
  endfunction

  task automatic push_line(input logic [15:0] b, input logic ack_last);
    cyc(2'b11, b, 16'(b + 1), 1'b0, 1'b0);
    cyc(2'b11, 16'(b + 2), 16'(b + 3), 1'b0, 1'b0);
    cyc(2'b11, 16'(b + 4), 16'(b + 5), 1'b0, ack_last);
  endtask

  initial begin
    tbl[0]  = '{2'b11, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 96'h0, 3'd0, 1'b0};
    tbl[1]  = '{2'b11, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0, 96'h0, 3'd0, 1'b0};
    tbl[2]  = '{2'b11, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b1,
                96'h0001_0002_0003_0004_0005_0006, 3'd1, 1'b0};
    tbl[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 96'h0, 3'd0, 1'b1};
    tbl[4]  = '{2'b11, 16'h000A, 16'h000B, 1'b0, 1'b0, 1'b0, 96'h0, 3'd0, 1'b0};
    tbl[5]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1,
                96'h000A_000B_0000_0000_0000_0000, 3'd1, 1'b0};
    tbl[6]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 96'h0, 3'd0, 1'b1};
    tbl[7]  = '{2'b11, 16'h0011, 16'h0012, 1'b0, 1'b0, 1'b0, 96'h0, 3'd0, 1'b0};
    tbl[8]  = '{2'b11, 16'h0013, 16'h0014, 1'b0, 1'b0, 1'b0, 96'h0, 3'd0, 1'b0};
    tbl[9]  = '{2'b10, 16'hDEAD, 16'h0015, 1'b0, 1'b0, 1'b0, 96'h0, 3'd0, 1'b0};
    tbl[10] = '{2'b11, 16'h00C1, 16'h00C2, 1'b1, 1'b0, 1'b1,
                96'h0011_0012_0013_0014_0015_00C1, 3'd1, 1'b0};
    tbl[11] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1,
                96'h0011_0012_0013_0014_0015_00C1, 3'd2, 1'b0};
    tbl[12] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1,
                96'h00C2_0000_0000_0000_0000_0000, 3'd1, 1'b0};
    tbl[13] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 96'h0, 3'd0, 1'b1};

    rst_in = 1'b0;
    fma_valid_in = '0;
    fma_result_in = '0;
    flush_in = 1'b0;
    write_buffer_ack_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_state("reset", 1'b0, 96'h0, 3'd0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].fl, tbl[i].ack);
      check_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].ec, 1'b0, tbl[i].ei, 1'b0);
    end

    // Fill the FIFO, overflow it, then push alongside a pop while full.
    for (int n = 0; n < 4; n++) push_line(16'(16'h0100 * (n + 1)), 1'b0);
    check_state("full4", 1'b1, mkline(16'h0100), 3'd4, 1'b1, 1'b0, 1'b0);
    push_line(16'h0500, 1'b0);
    check_state("drop5", 1'b1, mkline(16'h0100), 3'd4, 1'b1, 1'b0, 1'b1);
    push_line(16'h0600, 1'b1);
    check_state("pushpop", 1'b1, mkline(16'h0200), 3'd4, 1'b1, 1'b0, 1'b1);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    check_state("drain1", 1'b1, mkline(16'h0300), 3'd3, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    check_state("drain2", 1'b1, mkline(16'h0400), 3'd2, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    check_state("drain3", 1'b1, mkline(16'h0600), 3'd1, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    check_state("drain4", 1'b0, 96'h0, 3'd0, 1'b0, 1'b1, 1'b1);
    cyc(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    check_state("ack_empty", 1'b0, 96'h0, 3'd0, 1'b0, 1'b1, 1'b1);

    // Two lines queued plus a partial line, then asynchronous reset.
    push_line(16'h0700, 1'b0);
    push_line(16'h0800, 1'b0);
    cyc(2'b11, 16'h0091, 16'h0092, 1'b0, 1'b0);
    check_state("pre_rst", 1'b1, mkline(16'h0700), 3'd2, 1'b0, 1'b0, 1'b1);
    rst_in = 1'b0;
    fma_valid_in = '0;
    #1;
    check_state("mid_rst", 1'b0, 96'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    push_line(16'h0021, 1'b0);
    check_state("post_rst", 1'b1, mkline(16'h0021), 3'd1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
